// File: rtl/mips_writeback.sv
// mips_writeback: write side of the 32x32 MIPS register file.
// Takes one retiring instruction per handshake, picks the destination
// register, forms the write value (ALU, lui, jal link or an extended load
// lane) and issues a single-cycle write strobe. Loads go through a
// request/valid memory handshake that is abandoned after MEM_TIMEOUT idle
// cycles.
module mips_writeback #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        misaligned,
    output logic        mem_timeout
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    // latched load context, valid while in WAIT_MEM
    logic [5:0]       ld_op;
    logic [1:0]       ld_off;
    logic [4:0]       ld_dst;

    // decode of the instruction currently offered
    logic             accept;
    logic             is_load;
    logic             is_write;
    logic             is_misal;
    logic [4:0]       dst;
    logic [31:0]      nl_data;

    // Lane extraction: byte/half picked by the latched offset, then extended.
    function automatic logic [31:0] extract(input logic [5:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   extract = {{24{b[7]}}, b};
            OP_LBU:  extract = {24'h0, b};
            OP_LH:   extract = {{16{h[15]}}, h};
            OP_LHU:  extract = {16'h0, h};
            default: extract = word;
        endcase
    endfunction

    // Handshake: only IDLE can take a new instruction, never under reset.
    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready;

    assign cnt_inc     = cnt + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(MEM_TIMEOUT));

    // Opcode decode: classify, pick destination, form non-load data.
    always_comb begin
        is_load  = 1'b0;
        is_write = 1'b0;
        is_misal = 1'b0;
        dst      = rt;
        nl_data  = alu_result;
        case (opcode)
            OP_RTYPE: begin
                is_write = 1'b1;
                dst      = rd;
            end
            OP_JAL: begin
                is_write = 1'b1;
                dst      = 5'd31;
                nl_data  = pc + 32'd4;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: begin
                is_write = 1'b1;
            end
            OP_LUI: begin
                is_write = 1'b1;
                nl_data  = {imm, 16'h0000};
            end
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                is_misal = alu_result[0];
            end
            OP_LW: begin
                is_load  = 1'b1;
                is_misal = |alu_result[1:0];
            end
            default: ;
        endcase
    end

    // Next-state: enter WAIT_MEM on an aligned load, leave on data or timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_load && !is_misal)
                    state_nx = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (mem_rvalid || timeout_hit)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counter, load context and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ld_op       <= '0;
            ld_off      <= '0;
            ld_dst      <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            misaligned  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            rf_we      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        if (is_load) begin
                            if (is_misal) begin
                                misaligned <= 1'b1;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_addr <= {alu_result[31:2], 2'b00};
                                ld_op    <= opcode;
                                ld_off   <= alu_result[1:0];
                                ld_dst   <= dst;
                            end
                        end else if (is_write) begin
                            // $0 is never written but the address/data still track
                            rf_we    <= (dst != 5'd0);
                            rf_waddr <= dst;
                            rf_wdata <= nl_data;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        mem_req  <= 1'b0;
                        rf_we    <= (ld_dst != 5'd0);
                        rf_waddr <= ld_dst;
                        rf_wdata <= extract(ld_op, ld_off, mem_rdata);
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        mem_timeout <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_writeback.sv
// tb_mips_writeback: directed vectors with a scoreboard. Stimulus pushes the
// expected write/misaligned event; a monitor pops and compares whenever the
// DUT pulses rf_we or misaligned.
module tb_mips_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [15:0] imm = '0;
    logic [31:0] pc = '0;
    logic [31:0] alu_result = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misaligned;
    logic        mem_timeout;

    mips_writeback #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rt(rt), .rd(rd), .imm(imm), .pc(pc),
        .alu_result(alu_result), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misaligned(misaligned),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.mis = 1'b0; e.a = a; e.d = d;
        return e;
    endfunction

    function automatic exp_t mis();
        exp_t e;
        e.mis = 1'b1; e.a = '0; e.d = '0;
        return e;
    endfunction

    // Monitor: every write strobe or misaligned pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rf_we || misaligned) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'({rf_we, misaligned}), 32'd0);
                end else begin
                    e = q.pop_front();
                    if (e.mis) begin
                        chk("mis_pulse", 32'({rf_we, misaligned}), 32'b01);
                    end else begin
                        chk("we_only", 32'({rf_we, misaligned}), 32'b10);
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
                        chk("rf_wdata", rf_wdata, e.d);
                    end
                end
            end
        end
    end

    // All tasks are entered and left at #1 after a rising edge.
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] t, input logic [4:0] d,
                         input logic [15:0] im, input logic [31:0] p, input logic [31:0] a);
        int n = 0;
        while (!in_ready && n < 50) begin step(1); n++; end
        chk("issue_ready", 32'(in_ready), 32'd1);
        opcode = op; rt = t; rd = d; imm = im; pc = p; alu_result = a;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
    endtask

    // Aligned load: data returned in the (dly+1)-th cycle of mem_req.
    task automatic load(input logic [5:0] op, input logic [4:0] t, input logic [31:0] a,
                        input logic [31:0] rdata, input int dly, input exp_t e);
        issue(op, t, 5'd0, 16'h0, 32'h0, a);
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_addr", mem_addr, {a[31:2], 2'b00});
        chk("ld_busy", 32'(in_ready), 32'd0);
        step(dly);
        q.push_back(e);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step(1);
        mem_rvalid = 1'b0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        chk("ld_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        // reset state
        step(3);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", {25'd0, rf_we, mem_req, misaligned, mem_timeout, 3'd0}, 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // non-load writes, back to back
        q.push_back(wr(5'd5, 32'h1234_5678));
        issue(6'b000000, 5'd3, 5'd5, 16'h0, 32'h0, 32'h1234_5678);
        chk("rtype_ready", 32'(in_ready), 32'd1);
        q.push_back(wr(5'd9, 32'hBEEF_0000));
        issue(6'b001111, 5'd9, 5'd2, 16'hBEEF, 32'h0, 32'hDEAD_DEAD);
        q.push_back(wr(5'd31, 32'h0040_0014));
        issue(6'b000011, 5'd7, 5'd8, 16'h0, 32'h0040_0010, 32'h0);
        q.push_back(wr(5'd11, 32'h0000_00AB));
        issue(6'b001101, 5'd11, 5'd1, 16'h0, 32'h0, 32'h0000_00AB);
        q.push_back(wr(5'd31, 32'h0000_0000));
        issue(6'b000011, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFC, 32'h0);
        step(1);

        // loads and lane extraction
        load(6'b100000, 5'd4, 32'h1003, 32'h80FF_7F01, 2, wr(5'd4, 32'hFFFF_FF80));
        load(6'b100100, 5'd4, 32'h1003, 32'h80FF_7F01, 2, wr(5'd4, 32'h0000_0080));
        load(6'b100001, 5'd4, 32'h1002, 32'h80FF_7F01, 2, wr(5'd4, 32'hFFFF_80FF));
        load(6'b100101, 5'd6, 32'h1000, 32'h80FF_7F01, 0, wr(5'd6, 32'h0000_7F01));
        load(6'b100000, 5'd7, 32'h1001, 32'h80FF_7F01, 1, wr(5'd7, 32'h0000_007F));
        load(6'b100011, 5'd8, 32'h1004, 32'h80FF_7F01, 5, wr(5'd8, 32'h80FF_7F01));

        // misaligned loads
        q.push_back(mis());
        issue(6'b100011, 5'd10, 5'd0, 16'h0, 32'h0, 32'h1002);
        chk("mis_lw_noreq", 32'(mem_req), 32'd0);
        chk("mis_lw_ready", 32'(in_ready), 32'd1);
        q.push_back(mis());
        issue(6'b100001, 5'd10, 5'd0, 16'h0, 32'h0, 32'h1001);
        chk("mis_lh_noreq", 32'(mem_req), 32'd0);
        step(2);
        chk("mis_hold_wdata", rf_wdata, 32'h80FF_7F01);

        // timeout
        issue(6'b100011, 5'd3, 5'd0, 16'h0, 32'h0, 32'h2000);
        n = 0;
        while (mem_req && n < 40) begin n++; step(1); end
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_flag", 32'(mem_timeout), 32'd1);
        chk("to_ready", 32'(in_ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step(1);
        mem_rvalid = 1'b0;
        step(2);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_no_req", 32'(mem_req), 32'd0);

        // destination $0: no strobe, address/data still update
        issue(6'b000000, 5'd1, 5'd0, 16'h0, 32'h0, 32'hCAFE_F00D);
        chk("r0_we", 32'(rf_we), 32'd0);
        chk("r0_waddr", 32'(rf_waddr), 32'd0);
        chk("r0_wdata", rf_wdata, 32'hCAFE_F00D);

        // store opcode: accepted, nothing happens
        issue(6'b101011, 5'd6, 5'd0, 16'h0, 32'h0, 32'h4000);
        chk("st_noreq", 32'(mem_req), 32'd0);
        chk("st_hold", rf_wdata, 32'hCAFE_F00D);
        step(1);

        // reset while waiting for memory
        issue(6'b100011, 5'd8, 5'd0, 16'h0, 32'h0, 32'h3000);
        chk("rw_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("rw_req_drop", 32'(mem_req), 32'd0);
        chk("rw_ready", 32'(in_ready), 32'd0);
        chk("rw_outs", {27'd0, rf_we, misaligned, mem_timeout, 2'd0}, 32'd0);
        chk("rw_wdata", rf_wdata, 32'd0);
        chk("rw_maddr", mem_addr, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        step(1);
        rst_n = 1'b1;
        step(1);
        mem_rvalid = 1'b0;
        step(1);

        // recovery after reset
        q.push_back(wr(5'd12, 32'h0BAD_CAFE));
        issue(6'b000000, 5'd0, 5'd12, 16'h0, 32'h0, 32'h0BAD_CAFE);
        step(3);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
